alu_req_arbiter: RTL and testbench
==================================

Name: alu_req_arbiter

Overview:
- Shares one combinational ALU between two requesters (e.g. execute-stage issue and a debug/test port).
- Each request carries an 8-bit one-hot op-control word plus two operands.
- The block performs three steps for each request:
  - arbitrates between the requesters round-robin;
  - decodes the control word to the 4-bit ALU control code;
  - drives the ALU operands for a fixed number of cycles, then returns the registered result on a shared response channel tagged with the requester id.

Parameters:
- WIDTH, 32, operand/result width in bits.
- ALU_LAT, 1, cycles operands are held on the ALU before the result is sampled (legal 1..15).

Ports:
- clk  input  1  the single clock; all state updates on rising edge.
- rst_n  input  1  asynchronous reset, active-low.
- req_valid  input  2  per-requester request valid (bit i = requester i).
- req_ready  output  2  per-requester accept; at most one bit set.
- req_control0 / req_control1  input  8 each  one-hot op-control word per requester.
- req_a0 / req_a1, req_b0 / req_b1  input  WIDTH each  operands per requester.
- alu_a, alu_b  output  WIDTH  operands driven to the ALU.
- alu_control  output  4  ALU control code.
- alu_result  input  WIDTH  combinational ALU result.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response accept.
- rsp_id  output  1  requester that owns the response.
- rsp_data  output  WIDTH  captured result.
- rsp_err  output  1  control word was not a legal code.
- busy  output  1  high whenever state is not IDLE.

Behaviour:
- Reset:
  - Asynchronous on rst_n low; all of the following take effect immediately, independent of clk.
  - state=IDLE.
  - alu_a=0, alu_b=0, alu_control=4'b0000.
  - rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, busy=0, req_ready=2'b00.
  - last_grant=1, so requester 0 wins the first contention.
- States: IDLE, ISSUE, RESP.
- IDLE:
  - grant = the only valid requester; if both are valid, the one != last_grant.
  - req_ready[grant] is combinational: high only in IDLE, with rst_n high and req_valid[grant] high.
  - On handshake, latch control/operands into alu_a/alu_b/alu_control and latch id; set last_grant=grant.
- Decode: 8'b10000000 -> 4'b0000 (signed); 8'b01000000 -> 4'b0001 (unsigned).
- Illegal control (any other value, including 0 and multi-hot):
  - Skip ISSUE and go straight to RESP.
  - rsp_data=0, rsp_err=1; alu_control stays 4'b0000.
- ISSUE:
  - A 4-bit counter loads ALU_LAT-1 on entry and decrements each cycle.
  - When the counter reaches 0, capture alu_result into rsp_data, set rsp_err=0, and go to RESP.
  - alu_a, alu_b and alu_control are stable throughout ISSUE.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_err are held stable until rsp_ready.
  - On rsp_valid&rsp_ready, go to IDLE; rsp_valid drops the next cycle.
  - No new request is accepted in the handshake cycle.
- Latency (legal op): handshake edge N -> ISSUE cycles N+1..N+ALU_LAT -> rsp_valid first high in cycle N+ALU_LAT+1.
- Latency (illegal op): rsp_valid high in cycle N+1.
- Throughput: one op per ALU_LAT+2 cycles at best; req_ready is 0 in ISSUE and RESP.
- ALU outputs keep the last operands after completion; they are not cleared.
- A requester dropping req_valid before its grant is legal; no state change results.
- Reset mid-ISSUE or mid-RESP: the in-flight operation and response are discarded; no rsp_valid after reset release until a new handshake.

Decomposition:
- Package alu_ctrl_pkg holds:
  - CTRL_SIGNED=8'b10000000, CTRL_UNSIGNED=8'b01000000;
  - ALUCTL_SIGNED=4'b0000, ALUCTL_UNSIGNED=4'b0001;
  - the state encoding IDLE/ISSUE/RESP.
- One combinational sub-module, alu_ctrl_decode: control[7:0] -> alu_control[3:0] plus illegal flag, using the package constants.

Test Plan:
- Req0 only, control=8'h80, a=5, b=3, ALU_LAT=1, rsp_ready=1:
  - req_ready[0] is high in the handshake cycle;
  - alu_control=0000, alu_a=5, alu_b=3 next cycle;
  - rsp_valid two cycles after the handshake, with rsp_id=0, rsp_data=alu_result, rsp_err=0.
- Both requesters valid continuously, legal ops: grants alternate 0,1,0,1; each response tagged with the matching rsp_id.
- Req1 control=8'h41 (multi-hot): rsp_valid one cycle after the handshake, with rsp_err=1, rsp_data=0, rsp_id=1; alu_control stays 0000.
- rsp_ready held low 5 cycles after rsp_valid:
  - rsp fields are stable for all 5 cycles;
  - req_ready=00 throughout;
  - busy=1 until the handshake;
  - next accept occurs the cycle after return to IDLE.
- ALU_LAT=3, control=8'h40:
  - alu_control=0001 held 3 cycles;
  - alu_result sampled at the end of the 3rd cycle;
  - rsp_valid at handshake+4.
- rst_n pulsed low during ISSUE: all outputs are 0 immediately; after release, req0 wins first contention; no stray rsp_valid.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared constants for the ALU request arbiter.
// Contents: the legal one-hot op-control words, the ALU control codes
// they map to, the FSM state encoding, and the issue counter width.
package alu_ctrl_pkg;

  // One-hot op-control words accepted from requesters
  localparam logic [7:0] CTRL_SIGNED   = 8'b1000_0000;
  localparam logic [7:0] CTRL_UNSIGNED = 8'b0100_0000;

  // ALU control codes driven to the shared ALU
  localparam logic [3:0] ALUCTL_SIGNED   = 4'b0000;
  localparam logic [3:0] ALUCTL_UNSIGNED = 4'b0001;

  // FSM state encoding
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_RESP  = 2'd2;

  // Issue-phase latency counter width (ALU_LAT up to 15)
  localparam int unsigned CNT_W = 4;

endpackage

// File: rtl/alu_req_arbiter_if.sv
// Bus bundle between the ALU request arbiter and its environment.
// Groups the two request channels, the ALU drive/result signals, the
// response channel and the busy status.
//   slave  : arbiter side (drives req_ready, ALU operands, response, busy)
//   master : environment side (requesters, ALU result, response consumer)
interface alu_req_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic [1:0]       req_valid;
  logic [1:0]       req_ready;
  logic [7:0]       req_control0;
  logic [7:0]       req_control1;
  logic [WIDTH-1:0] req_a0;
  logic [WIDTH-1:0] req_a1;
  logic [WIDTH-1:0] req_b0;
  logic [WIDTH-1:0] req_b1;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [3:0]       alu_control;
  logic [WIDTH-1:0] alu_result;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req_valid, req_control0, req_control1,
           req_a0, req_a1, req_b0, req_b1,
           alu_result, rsp_ready,
    output req_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req_valid, req_control0, req_control1,
           req_a0, req_a1, req_b0, req_b1,
           alu_result, rsp_ready,
    input  req_ready, alu_a, alu_b, alu_control,
           rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

endinterface

// File: rtl/alu_ctrl_decode.sv
// Combinational op-control decoder.
// Ports:
//   control_i     : 8-bit one-hot op-control word
//   alu_control_o : 4-bit ALU control code (ALUCTL_SIGNED when illegal)
//   illegal_o     : control word is not one of the legal codes
module alu_ctrl_decode
  import alu_ctrl_pkg::*;
(
  input  logic [7:0] control_i,
  output logic [3:0] alu_control_o,
  output logic       illegal_o
);

  // Exact-match decode; zero and multi-hot words fall to illegal
  always_comb begin
    alu_control_o = ALUCTL_SIGNED;
    illegal_o     = 1'b0;
    case (control_i)
      CTRL_SIGNED:   alu_control_o = ALUCTL_SIGNED;
      CTRL_UNSIGNED: alu_control_o = ALUCTL_UNSIGNED;
      default:       illegal_o     = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_req_arbiter.sv
// Shares one combinational ALU between two requesters.
// Round-robin arbitration in IDLE, operand hold for ALU_LAT cycles in
// ISSUE, then a registered, id-tagged response held in RESP until taken.
// Ports:
//   clk   : clock, rising-edge
//   rst_n : asynchronous active-low reset
//   bus   : request/ALU/response bundle (slave side)
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned ALU_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_req_arbiter_if.slave  bus
);

  logic [1:0]       state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [3:0]       alu_ctl_q, alu_ctl_d;
  logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             any_valid_c;
  logic             grant_c;
  logic             accept_c;
  logic [7:0]       sel_ctrl_c;
  logic [WIDTH-1:0] sel_a_c;
  logic [WIDTH-1:0] sel_b_c;
  logic [3:0]       dec_ctl_c;
  logic             dec_illegal_c;

  // Round-robin pick: sole requester, or the one not granted last time
  always_comb begin
    any_valid_c = |bus.req_valid;
    grant_c     = (&bus.req_valid) ? ~last_grant_q : bus.req_valid[1];
    accept_c    = (state_q == ST_IDLE) && rst_n && any_valid_c;
    sel_ctrl_c  = grant_c ? bus.req_control1 : bus.req_control0;
    sel_a_c     = grant_c ? bus.req_a1 : bus.req_a0;
    sel_b_c     = grant_c ? bus.req_b1 : bus.req_b0;
  end

  alu_ctrl_decode u_decode (
    .control_i     (sel_ctrl_c),
    .alu_control_o (dec_ctl_c),
    .illegal_o     (dec_illegal_c)
  );

  // Next-state and datapath update
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    id_d         = id_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_ctl_d    = alu_ctl_q;
    rsp_data_d   = rsp_data_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;

    case (state_q)
      ST_IDLE: begin
        if (accept_c) begin
          last_grant_d = grant_c;
          id_d         = grant_c;
          alu_a_d      = sel_a_c;
          alu_b_d      = sel_b_c;
          alu_ctl_d    = dec_ctl_c;
          if (dec_illegal_c) begin
            // Illegal op never touches the ALU; answer straight away
            rsp_data_d = '0;
            rsp_err_d  = 1'b1;
            state_d    = ST_RESP;
          end else begin
            cnt_d   = CNT_W'(ALU_LAT - 1);
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (cnt_q == '0) begin
          rsp_data_d = bus.alu_result;
          rsp_err_d  = 1'b0;
          state_d    = ST_RESP;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_RESP: begin
        if (bus.rsp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers; last_grant resets to 1 so requester 0 wins first
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_ctl_q    <= ALUCTL_SIGNED;
      rsp_data_q   <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      id_q         <= id_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_ctl_q    <= alu_ctl_d;
      rsp_data_q   <= rsp_data_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
    end
  end

  // Accept is only offered to the granted requester while idle
  assign bus.req_ready   = accept_c ? (grant_c ? 2'b10 : 2'b01) : 2'b00;
  assign bus.alu_a       = alu_a_q;
  assign bus.alu_b       = alu_b_q;
  assign bus.alu_control = alu_ctl_q;
  assign bus.rsp_valid   = (state_q == ST_RESP);
  assign bus.rsp_id      = id_q;
  assign bus.rsp_data    = rsp_data_q;
  assign bus.rsp_err     = rsp_err_q;
  assign bus.busy        = (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Self-checking bench for alu_req_arbiter: one instance with ALU_LAT=1
// (vector table, reset/alternation/backpressure sequences, random run
// against a transaction-level model) and one with ALU_LAT=3.
module tb_alu_req_arbiter;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n;
  logic [W-1:0] res3;

  always #5 clk = ~clk;

  alu_req_arbiter_if #(.WIDTH(W)) bus1 ();
  alu_req_arbiter_if #(.WIDTH(W)) bus3 ();

  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  alu_req_arbiter #(.WIDTH(W), .ALU_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // Stand-in ALU: signed code subtracts, unsigned code adds
  function automatic logic [W-1:0] tb_alu(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [3:0] c);
    if (c == 4'b0000) return a - b;
    if (c == 4'b0001) return a + b;
    return '0;
  endfunction

  assign bus1.alu_result = tb_alu(bus1.alu_a, bus1.alu_b, bus1.alu_control);
  assign bus3.alu_result = res3;

  // Reference: response a request should produce
  function automatic logic is_legal(input logic [7:0] c);
    return (c == 8'h80) || (c == 8'h40);
  endfunction

  function automatic logic [W-1:0] ref_data(input logic [7:0] c, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    if (c == 8'h80) return a - b;
    if (c == 8'h40) return a + b;
    return '0;
  endfunction

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive1(input logic [1:0] v, input logic [7:0] c0, input logic [7:0] c1,
                        input logic [W-1:0] a0, input logic [W-1:0] b0,
                        input logic [W-1:0] a1, input logic [W-1:0] b1);
    bus1.req_valid    = v;
    bus1.req_control0 = c0;
    bus1.req_control1 = c1;
    bus1.req_a0       = a0;
    bus1.req_b0       = b0;
    bus1.req_a1       = a1;
    bus1.req_b1       = b1;
  endtask

  // Called at the first negedge after a handshake; returns the cycle index of rsp_valid (0 = timeout)
  task automatic wait_rsp1(output int lat);
    lat = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k > 1) @(negedge clk);
      if (bus1.rsp_valid) begin
        lat = k;
        break;
      end
    end
  endtask

  typedef struct {
    logic [1:0]   valid;
    logic [7:0]   c0;
    logic [7:0]   c1;
    logic [W-1:0] a0;
    logic [W-1:0] b0;
    logic [W-1:0] a1;
    logic [W-1:0] b1;
    logic         exp_id;
    logic         exp_err;
    logic [W-1:0] exp_data;
    logic [3:0]   exp_ctl;
  } vec_t;

  vec_t vecs[8];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int lat;
    int ngr;
    int nrsp;
    logic        s_id;
    logic [W-1:0] s_data;
    logic        s_err;
    logic        pend;
    logic        last;
    logic        p_id;
    logic        p_err;
    logic [W-1:0] p_data;
    int          due;
    logic        g;
    logic [1:0]  rv;
    logic [7:0]  rc[2];
    logic [W-1:0] ra[2];
    logic [W-1:0] rb[2];

    // Expected values worked by hand from round-robin order (last grant starts at 1)
    vecs[0] = '{2'b11, 8'h80, 8'h40, 32'd5,  32'd3, 32'd1,          32'd1, 1'b0, 1'b0, 32'd2,          4'h0};
    vecs[1] = '{2'b11, 8'h40, 8'h80, 32'd10, 32'd20, 32'd100,       32'd1, 1'b1, 1'b0, 32'd99,         4'h0};
    vecs[2] = '{2'b01, 8'h40, 8'h00, 32'd7,  32'd8, 32'd0,          32'd0, 1'b0, 1'b0, 32'd15,         4'h1};
    vecs[3] = '{2'b10, 8'h00, 8'h41, 32'd0,  32'd0, 32'd9,          32'd9, 1'b1, 1'b1, 32'd0,          4'h0};
    vecs[4] = '{2'b01, 8'h00, 8'h00, 32'd4,  32'd4, 32'd0,          32'd0, 1'b0, 1'b1, 32'd0,          4'h0};
    vecs[5] = '{2'b10, 8'h00, 8'h40, 32'd0,  32'd0, 32'hFFFF_FFFF,  32'd2, 1'b1, 1'b0, 32'd1,          4'h1};
    vecs[6] = '{2'b01, 8'h80, 8'h00, 32'd0,  32'd1, 32'd0,          32'd0, 1'b0, 1'b0, 32'hFFFF_FFFF,  4'h0};
    vecs[7] = '{2'b11, 8'hFF, 8'h40, 32'd0,  32'd0, 32'd3,          32'd4, 1'b1, 1'b0, 32'd7,          4'h1};

    rst_n = 1'b1;
    res3  = '0;
    drive1(2'b00, 8'h00, 8'h00, '0, '0, '0, '0);
    bus1.rsp_ready    = 1'b1;
    bus3.req_valid    = 2'b00;
    bus3.req_control0 = 8'h00;
    bus3.req_control1 = 8'h00;
    bus3.req_a0       = '0;
    bus3.req_b0       = '0;
    bus3.req_a1       = '0;
    bus3.req_b1       = '0;
    bus3.rsp_ready    = 1'b1;

    // Reset values
    #2 rst_n = 1'b0;
    #1;
    check("rst_req_ready", bus1.req_ready, 2'b00);
    check("rst_rsp_valid", bus1.rsp_valid, 1'b0);
    check("rst_busy", bus1.busy, 1'b0);
    check("rst_alu_a", bus1.alu_a, 0);
    check("rst_alu_b", bus1.alu_b, 0);
    check("rst_alu_control", bus1.alu_control, 4'b0000);
    check("rst_rsp_data", bus1.rsp_data, 0);
    check("rst_rsp_id", bus1.rsp_id, 1'b0);
    check("rst_rsp_err", bus1.rsp_err, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Table-driven single transactions
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      drive1(vecs[i].valid, vecs[i].c0, vecs[i].c1, vecs[i].a0, vecs[i].b0, vecs[i].a1, vecs[i].b1);
      bus1.rsp_ready = 1'b1;
      @(negedge clk);
      check($sformatf("v%0d_req_ready", i), bus1.req_ready, vecs[i].exp_id ? 2'b10 : 2'b01);
      @(posedge clk); #1;
      bus1.req_valid = 2'b00;
      @(negedge clk);
      check($sformatf("v%0d_alu_control", i), bus1.alu_control, vecs[i].exp_ctl);
      check($sformatf("v%0d_alu_a", i), bus1.alu_a, vecs[i].exp_id ? vecs[i].a1 : vecs[i].a0);
      check($sformatf("v%0d_alu_b", i), bus1.alu_b, vecs[i].exp_id ? vecs[i].b1 : vecs[i].b0);
      check($sformatf("v%0d_busy", i), bus1.busy, 1'b1);
      wait_rsp1(lat);
      check($sformatf("v%0d_latency", i), lat, vecs[i].exp_err ? 1 : 2);
      check($sformatf("v%0d_rsp_id", i), bus1.rsp_id, vecs[i].exp_id);
      check($sformatf("v%0d_rsp_data", i), bus1.rsp_data, vecs[i].exp_data);
      check($sformatf("v%0d_rsp_err", i), bus1.rsp_err, vecs[i].exp_err);
      @(negedge clk);
      check($sformatf("v%0d_rsp_drop", i), bus1.rsp_valid, 1'b0);
    end

    // Reset in the middle of ISSUE
    @(posedge clk); #1;
    drive1(2'b01, 8'h80, 8'h00, 32'd5, 32'd3, '0, '0);
    @(posedge clk); #1;
    bus1.req_valid = 2'b00;
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_alu_a", bus1.alu_a, 0);
    check("mid_rst_alu_control", bus1.alu_control, 4'b0000);
    check("mid_rst_busy", bus1.busy, 1'b0);
    check("mid_rst_rsp_data", bus1.rsp_data, 0);
    check("mid_rst_rsp_id", bus1.rsp_id, 1'b0);
    check("mid_rst_rsp_valid", bus1.rsp_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("post_rst_no_rsp", {bus1.rsp_valid, bus1.busy}, 2'b00);
    end

    // Continuous contention: grants alternate starting with requester 0
    @(posedge clk); #1;
    drive1(2'b11, 8'h80, 8'h40, 32'd50, 32'd8, 32'd20, 32'd30);
    ngr = 0;
    nrsp = 0;
    for (int c = 0; c < 40 && nrsp < 4; c++) begin
      @(negedge clk);
      if (bus1.req_ready != 2'b00) begin
        check("alt_grant", bus1.req_ready, (ngr % 2 == 1) ? 2'b10 : 2'b01);
        ngr++;
      end
      if (bus1.rsp_valid) begin
        check("alt_rsp_id", bus1.rsp_id, (nrsp % 2 == 1) ? 1'b1 : 1'b0);
        check("alt_rsp_data", bus1.rsp_data, (nrsp % 2 == 1) ? 32'd50 : 32'd42);
        nrsp++;
      end
    end
    check("alt_rsp_count", nrsp, 4);
    @(posedge clk); #1;
    bus1.req_valid = 2'b00;

    // Response backpressure for 5 cycles with requester 1 waiting
    @(posedge clk); #1;
    drive1(2'b01, 8'h80, 8'h00, 32'd9, 32'd4, '0, '0);
    bus1.rsp_ready = 1'b0;
    @(negedge clk);
    check("bp_req_ready0", bus1.req_ready, 2'b01);
    @(posedge clk); #1;
    drive1(2'b10, 8'h00, 8'h40, '0, '0, 32'd1, 32'd2);
    @(negedge clk);
    wait_rsp1(lat);
    check("bp_latency", lat, 2);
    s_id = bus1.rsp_id;
    s_data = bus1.rsp_data;
    s_err = bus1.rsp_err;
    check("bp_first_rsp", {s_id, s_err, s_data}, {1'b0, 1'b0, 32'd5});
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      check("bp_hold_valid", bus1.rsp_valid, 1'b1);
      check("bp_hold_fields", {bus1.rsp_id, bus1.rsp_err, bus1.rsp_data}, {1'b0, 1'b0, 32'd5});
      check("bp_hold_req_ready", bus1.req_ready, 2'b00);
      check("bp_hold_busy", bus1.busy, 1'b1);
    end
    @(posedge clk); #1;
    bus1.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_hs_valid", bus1.rsp_valid, 1'b1);
    check("bp_hs_no_accept", bus1.req_ready, 2'b00);
    @(negedge clk);
    check("bp_next_accept", bus1.req_ready, 2'b10);
    check("bp_idle_busy", bus1.busy, 1'b0);
    @(posedge clk); #1;
    bus1.req_valid = 2'b00;
    @(negedge clk);
    wait_rsp1(lat);
    check("bp2_latency", lat, 2);
    check("bp2_rsp", {bus1.rsp_id, bus1.rsp_err, bus1.rsp_data}, {1'b1, 1'b0, 32'd3});
    @(negedge clk);

    // ALU_LAT=3: operands held three cycles, result taken from the third
    @(posedge clk); #1;
    bus3.req_valid    = 2'b01;
    bus3.req_control0 = 8'h40;
    bus3.req_a0       = 32'd11;
    bus3.req_b0       = 32'd22;
    @(negedge clk);
    check("lat3_req_ready", bus3.req_ready, 2'b01);
    @(posedge clk); #1;
    bus3.req_valid = 2'b00;
    for (int k = 1; k <= 3; k++) begin
      if (k > 1) begin
        @(posedge clk); #1;
      end
      res3 = 32'h100 + W'(k);
      @(negedge clk);
      check("lat3_alu_control", bus3.alu_control, 4'b0001);
      check("lat3_alu_ops", {bus3.alu_a, bus3.alu_b}, {32'd11, 32'd22});
      check("lat3_no_rsp", bus3.rsp_valid, 1'b0);
    end
    @(posedge clk); #1;
    res3 = 32'hDEAD;
    @(negedge clk);
    check("lat3_rsp_valid", bus3.rsp_valid, 1'b1);
    check("lat3_rsp_data", bus3.rsp_data, 32'h103);
    check("lat3_rsp_id_err", {bus3.rsp_id, bus3.rsp_err}, 2'b00);
    check("lat3_alu_control_kept", bus3.alu_control, 4'b0001);

    // Random traffic against a transaction-level model
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    pend = 1'b0;
    last = 1'b1;
    p_id = 1'b0;
    p_err = 1'b0;
    p_data = '0;
    due = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(posedge clk); #1;
      rv = 2'($urandom_range(0, 3));
      for (int r = 0; r < 2; r++) begin
        case ($urandom_range(0, 3))
          0: rc[r] = 8'h80;
          1: rc[r] = 8'h40;
          2: rc[r] = 8'($urandom);
          default: rc[r] = 8'h80;
        endcase
        ra[r] = $urandom;
        rb[r] = $urandom;
      end
      drive1(rv, rc[0], rc[1], ra[0], rb[0], ra[1], rb[1]);
      bus1.rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (!pend) begin
        g = (rv == 2'b11) ? ~last : rv[1];
        check("rnd_ready_idle", bus1.req_ready, (rv == 2'b00) ? 2'b00 : (g ? 2'b10 : 2'b01));
        check("rnd_valid_idle", bus1.rsp_valid, 1'b0);
        if (rv != 2'b00) begin
          pend   = 1'b1;
          last   = g;
          p_id   = g;
          p_err  = !is_legal(rc[g]);
          p_data = ref_data(rc[g], ra[g], rb[g]);
          due    = cyc + (p_err ? 1 : 2);
        end
      end else begin
        check("rnd_ready_busy", bus1.req_ready, 2'b00);
        if (cyc < due) begin
          check("rnd_valid_early", bus1.rsp_valid, 1'b0);
        end else begin
          check("rnd_valid", bus1.rsp_valid, 1'b1);
          check("rnd_rsp", {bus1.rsp_id, bus1.rsp_err, bus1.rsp_data}, {p_id, p_err, p_data});
          if (bus1.rsp_ready) pend = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
